// File: rtl/md_sequencer.sv
// E-stage multiply/divide unit: computes mult/multu/div/divu at issue and commits HI/LO after a fixed busy sequence.
// busy is combinational on issue so the hazard controller can stall dependent MD instructions in D in the same cycle.
module md_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  MDop,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        req,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        busy
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [3:0] L_MULT = 4'(MULT_CYCLES);
  localparam logic [3:0] L_DIV  = 4'(DIV_CYCLES);

  localparam logic [3:0] OP_MTHI  = 4'd3;
  localparam logic [3:0] OP_MTLO  = 4'd4;
  localparam logic [3:0] OP_MULT  = 4'd5;
  localparam logic [3:0] OP_MULTU = 4'd6;
  localparam logic [3:0] OP_DIV   = 4'd7;
  localparam logic [3:0] OP_DIVU  = 4'd8;

  logic [0:0]  r_state;
  logic [3:0]  r_count;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_pend_hi;
  logic [31:0] r_pend_lo;
  logic        r_pend_wr;

  logic        w_is_md;
  logic        w_issue;
  logic        w_sgn_mul;
  logic        w_sgn_div;
  logic [63:0] w_ma;
  logic [63:0] w_mb;
  logic [63:0] w_prod;
  logic [31:0] w_dn;
  logic [31:0] w_dd;
  logic [31:0] w_dd_safe;
  logic [31:0] w_q;
  logic [31:0] w_r;
  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;
  logic        w_res_wr;

  assign w_is_md = (MDop >= OP_MULT) && (MDop <= OP_DIVU);
  assign w_issue = (r_state == S_IDLE) && start && w_is_md && !req;
  assign busy    = (r_state == S_RUN) || w_issue;

  // One shared 64-bit multiplier: signedness is handled by how the operands are extended.
  assign w_sgn_mul = (MDop == OP_MULT);
  assign w_ma      = {{32{w_sgn_mul & rs_data[31]}}, rs_data};
  assign w_mb      = {{32{w_sgn_mul & rt_data[31]}}, rt_data};
  assign w_prod    = w_ma * w_mb;

  // Signed divide runs on magnitudes, then fixes signs; this also makes 0x80000000 / -1 wrap cleanly.
  assign w_sgn_div = (MDop == OP_DIV);
  assign w_dn      = (w_sgn_div && rs_data[31]) ? -rs_data : rs_data;
  assign w_dd      = (w_sgn_div && rt_data[31]) ? -rt_data : rt_data;
  assign w_dd_safe = (w_dd == 32'd0) ? 32'd1 : w_dd;
  assign w_q       = w_dn / w_dd_safe;
  assign w_r       = w_dn % w_dd_safe;

  always_comb begin
    w_res_hi = 32'd0;
    w_res_lo = 32'd0;
    w_res_wr = 1'b0;
    case (MDop)
      OP_MULT, OP_MULTU: begin
        w_res_hi = w_prod[63:32];
        w_res_lo = w_prod[31:0];
        w_res_wr = 1'b1;
      end
      OP_DIV: begin
        w_res_lo = (rs_data[31] ^ rt_data[31]) ? -w_q : w_q;
        w_res_hi = rs_data[31] ? -w_r : w_r;
        w_res_wr = (rt_data != 32'd0);
      end
      OP_DIVU: begin
        w_res_lo = w_q;
        w_res_hi = w_r;
        w_res_wr = (rt_data != 32'd0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_count   <= 4'd0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
      r_pend_wr <= 1'b0;
    end else if (r_state == S_RUN) begin
      r_count <= r_count - 4'd1;
      if (r_count == 4'd1) begin
        r_state <= S_IDLE;
        if (r_pend_wr) begin
          r_hi <= r_pend_hi;
          r_lo <= r_pend_lo;
        end
      end
    end else if (w_issue) begin
      r_pend_hi <= w_res_hi;
      r_pend_lo <= w_res_lo;
      r_pend_wr <= w_res_wr;
      r_count   <= (MDop <= OP_MULTU) ? L_MULT : L_DIV;
      r_state   <= S_RUN;
    end else if (!req) begin
      if (MDop == OP_MTHI) r_hi <= rs_data;
      if (MDop == OP_MTLO) r_lo <= rs_data;
    end
  end

  assign hi_out = r_hi;
  assign lo_out = r_lo;

endmodule

// File: tb/tb_md_sequencer.sv
// Directed table of MD operations, hand-written corner sequences, then random traffic against a cycle model.
module tb_md_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  MDop;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        req;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  md_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .MDop    (MDop),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .req     (req),
    .hi_out  (hi_out),
    .lo_out  (lo_out),
    .busy    (busy)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          nbusy;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic rq, input logic rst);
    start = s; MDop = op; rs_data = a; rt_data = b; req = rq; reset = rst;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues an op in the current cycle and counts busy cycles; ends in the first non-busy cycle.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output int nbusy);
    nbusy = 0;
    drive(1'b1, op, a, b, 1'b0, 1'b0);
    #1;
    while (busy && nbusy < 40) begin
      nbusy++;
      tick();
      drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
      #1;
    end
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  // Reference model: remaining busy cycles plus the result to commit.
  int          m_rem;
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  logic        m_pwr;

  function automatic logic is_md(input logic [3:0] op);
    return (op >= 4'd5) && (op <= 4'd8);
  endfunction

  task automatic model_step(input logic s, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic rq, input logic rst);
    int     ai, bi;
    longint la, lb, q, r;
    logic [63:0] p;
    if (rst) begin
      m_rem = 0; m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_pwr = 0;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0 && m_pwr) begin
        m_hi = m_phi;
        m_lo = m_plo;
      end
    end else if (s && is_md(op) && !rq) begin
      ai = a; bi = b;
      m_pwr = 1'b1;
      case (op)
        4'd5: begin la = ai; lb = bi; p = la * lb; end
        4'd6: begin p = {32'd0, a} * {32'd0, b}; end
        4'd7: begin
          la = ai; lb = bi;
          if (b == 0) m_pwr = 1'b0;
          else begin q = la / lb; r = la % lb; p = {r[31:0], q[31:0]}; end
        end
        default: begin
          la = {32'd0, a}; lb = {32'd0, b};
          if (b == 0) m_pwr = 1'b0;
          else begin q = la / lb; r = la % lb; p = {r[31:0], q[31:0]}; end
        end
      endcase
      if (m_pwr) begin
        m_phi = p[63:32];
        m_plo = p[31:0];
      end
      m_rem = (op <= 4'd6) ? 5 : 10;
    end else if (!rq) begin
      if (op == 4'd3) m_hi = a;
      if (op == 4'd4) m_lo = a;
    end
  endtask

  vec_t vecs[8];

  initial begin
    int n;
    logic s, rq, rst, eb;
    logic [3:0] op;
    logic [31:0] a, b;

    vecs[0] = '{4'd5, 32'hFFFFFFFB, 32'd3,         6,  32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[1] = '{4'd6, 32'hFFFFFFFF, 32'd2,         6,  32'h00000001, 32'hFFFFFFFE};
    vecs[2] = '{4'd7, 32'hFFFFFFF9, 32'd2,         11, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{4'd7, 32'h80000000, 32'hFFFFFFFF, 11, 32'h00000000, 32'h80000000};
    vecs[4] = '{4'd8, 32'd100,      32'd7,         11, 32'h00000002, 32'h0000000E};
    vecs[5] = '{4'd7, 32'd7,        32'hFFFFFFFE, 11, 32'h00000001, 32'hFFFFFFFD};
    vecs[6] = '{4'd5, 32'h80000000, 32'h80000000, 6,  32'h40000000, 32'h00000000};
    vecs[7] = '{4'd6, 32'hFFFFFFFF, 32'hFFFFFFFF, 6,  32'hFFFFFFFE, 32'h00000001};

    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    tick();
    tick();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_hi", hi_out, 32'd0);
    chk("reset_lo", lo_out, 32'd0);
    tick();

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, n);
      chk($sformatf("vec%0d_busy_cycles", i), n, vecs[i].nbusy);
      chk($sformatf("vec%0d_hi", i), hi_out, vecs[i].hi);
      chk($sformatf("vec%0d_lo", i), lo_out, vecs[i].lo);
      tick();
    end

    // mthi/mtlo preload, then divide by zero must leave them intact
    drive(1'b0, 4'd3, 32'h11, 32'd0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 4'd4, 32'h22, 32'd0, 1'b0, 1'b0);
    #1;
    chk("mthi_next_cycle", hi_out, 32'h11);
    tick();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    #1;
    chk("mtlo_next_cycle", lo_out, 32'h22);
    run_op(4'd8, 32'd5, 32'd0, n);
    chk("divu0_busy_cycles", n, 11);
    chk("divu0_hi", hi_out, 32'h11);
    chk("divu0_lo", lo_out, 32'h22);
    tick();

    // exception request cancels issue and mtlo
    drive(1'b1, 4'd5, 32'd3, 32'd4, 1'b1, 1'b0);
    #1;
    chk("req_issue_busy", {31'd0, busy}, 32'd0);
    tick();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    #1;
    chk("req_stays_idle", {31'd0, busy}, 32'd0);
    chk("req_hi", hi_out, 32'h11);
    chk("req_lo", lo_out, 32'h22);
    drive(1'b0, 4'd4, 32'h99, 32'd0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    #1;
    chk("req_mtlo_lo", lo_out, 32'h22);
    tick();

    // reset in the third cycle of a div aborts it
    drive(1'b1, 4'd7, 32'd100, 32'd3, 1'b0, 1'b0);
    tick();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    #1;
    chk("abort_busy_before", {31'd0, busy}, 32'd1);
    tick();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", hi_out, 32'd0);
    chk("abort_lo", lo_out, 32'd0);
    run_op(4'd5, 32'd6, 32'd7, n);
    chk("post_abort_busy_cycles", n, 6);
    chk("post_abort_hi", hi_out, 32'd0);
    chk("post_abort_lo", lo_out, 32'd42);
    tick();

    // random traffic against the model, starting from a reset cycle
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    model_step(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    tick();
    for (int k = 0; k < 1500; k++) begin
      s   = ($urandom_range(0, 2) == 0);
      op  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0) op = 4'($urandom_range(3, 8));
      a   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 50)) : $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'hFFFFFFFF;
        2, 3:    b = 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      rq  = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 199) == 0);
      drive(s, op, a, b, rq, rst);
      #1;
      eb = (m_rem > 0) || (s && is_md(op) && !rq);
      chk("rand_busy", {31'd0, busy}, {31'd0, eb});
      chk("rand_hi", hi_out, m_hi);
      chk("rand_lo", lo_out, m_lo);
      model_step(s, op, a, b, rq, rst);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
